// File: rtl/sine_table_sequencer.sv
// sine_table_sequencer: control stage in front of a single-port sample RAM.
//   Loads a 2^ADDR_WIDTH sample table in order, then replays it through a phase
//   accumulator as a continuous waveform stream with valid/ready backpressure.
// Latency: the read address is presented in cycle N and sample_valid rises in
//   cycle N+2. Throughput is one sample per cycle while sample_ready is high.
// Backpressure: load_ready is high throughout LOAD, and gaps in load_valid just
//   stall the load. In RUN, reads stop issuing once the 2-entry output buffer
//   plus the read in flight would exceed two entries.
//
// Ports:
//   clk, rst                  clock; asynchronous active-high reset
//   start_load                request a table load (sampled only in IDLE)
//   load_data/valid/ready     sample stream being written to the table
//   load_done                 one-cycle pulse after the last table write
//   run_en, tuning_word       generate the waveform while run_en is high;
//                             tuning_word is the phase step per issued read
//   sample/valid/ready        output waveform stream
//   mem_data/addr/we, mem_q   RAM interface (mem_q is valid one cycle after addr)

`ifndef DATA_LEN
`define DATA_LEN 8
`endif
`ifndef ROWS_BASE_2
`define ROWS_BASE_2 4
`endif

module sine_table_sequencer #(
    parameter int DATA_WIDTH  = `DATA_LEN,
    parameter int ADDR_WIDTH  = `ROWS_BASE_2,
    parameter int PHASE_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_load,
    input  logic [DATA_WIDTH-1:0]  load_data,
    input  logic                   load_valid,
    output logic                   load_ready,
    output logic                   load_done,
    input  logic                   run_en,
    input  logic [PHASE_WIDTH-1:0] tuning_word,
    output logic [DATA_WIDTH-1:0]  sample,
    output logic                   sample_valid,
    input  logic                   sample_ready,
    output logic [DATA_WIDTH-1:0]  mem_data,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    output logic                   mem_we,
    input  logic [DATA_WIDTH-1:0]  mem_q
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    state_t                  state_q,    state_d;
    logic [PHASE_WIDTH-1:0]  phase_q,    phase_d;
    logic [ADDR_WIDTH-1:0]   load_cnt_q, load_cnt_d;
    logic                    loaded_q,   loaded_d;
    logic                    load_done_q, load_done_d;
    logic                    rd_pend_q,  rd_pend_d;

    // Two-entry output buffer: head drives the sample port directly, so the
    // output is always straight from a register.
    logic [DATA_WIDTH-1:0]   head_q,     head_d;
    logic                    head_vld_q, head_vld_d;
    logic [DATA_WIDTH-1:0]   tail_q,     tail_d;
    logic                    tail_vld_q, tail_vld_d;

    logic                    pop;
    logic                    push;
    logic                    issue;
    logic [1:0]              occ;

    // ---------------------------------------------------------------------
    // Next-state and output decode
    // ---------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        load_cnt_d  = load_cnt_q;
        loaded_d    = loaded_q;
        load_done_d = 1'b0;
        rd_pend_d   = 1'b0;
        issue       = 1'b0;

        load_ready  = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_data    = '0;

        pop  = head_vld_q & sample_ready;
        push = rd_pend_q;

        // Slots that will be committed after this cycle. A read issued now
        // lands two edges later, so it must fit behind everything already
        // buffered or in flight, less the entry leaving this cycle. occ never
        // exceeds 2 (the issue rule guarantees it), so 2 bits are enough.
        occ = 2'({1'b0, head_vld_q}) + 2'({1'b0, tail_vld_q})
            + 2'({1'b0, rd_pend_q})  - 2'({1'b0, pop});

        unique case (state_q)
            ST_IDLE: begin
                if (start_load) begin
                    state_d    = ST_LOAD;
                    load_cnt_d = '0;
                end else if (run_en && loaded_q) begin
                    state_d = ST_RUN;
                    phase_d = '0;
                end
            end

            ST_LOAD: begin
                load_ready = 1'b1;
                mem_we     = load_valid;
                mem_addr   = load_cnt_q;
                mem_data   = load_data;
                if (load_valid) begin
                    load_cnt_d = load_cnt_q + 1'b1;
                    if (load_cnt_q == LAST_ADDR) begin
                        loaded_d    = 1'b1;
                        load_done_d = 1'b1;
                        state_d     = ST_IDLE;
                    end
                end
            end

            ST_RUN: begin
                mem_addr = phase_q[PHASE_WIDTH-1 -: ADDR_WIDTH];
                issue    = run_en && (occ < 2'd2);
                if (issue) begin
                    rd_pend_d = 1'b1;
                    phase_d   = phase_q + tuning_word;
                end
                // Leave only once nothing is in flight or buffered. A valid
                // tail implies a valid head, so head_vld covers both entries.
                if (!run_en && !rd_pend_q && !head_vld_q) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Output buffer update
    // ---------------------------------------------------------------------
    always_comb begin
        head_d     = head_q;
        head_vld_d = head_vld_q;
        tail_d     = tail_q;
        tail_vld_d = tail_vld_q;

        unique case ({push, pop})
            2'b11: begin
                // Simultaneous push and pop: the occupancy is unchanged.
                if (tail_vld_q) begin
                    head_d = tail_q;
                    tail_d = mem_q;
                end else begin
                    head_d = mem_q;
                end
            end
            2'b01: begin
                if (tail_vld_q) begin
                    head_d     = tail_q;
                    tail_vld_d = 1'b0;
                end else begin
                    head_vld_d = 1'b0;
                end
            end
            2'b10: begin
                if (!head_vld_q) begin
                    head_d     = mem_q;
                    head_vld_d = 1'b1;
                end else begin
                    tail_d     = mem_q;
                    tail_vld_d = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // State registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            phase_q     <= '0;
            load_cnt_q  <= '0;
            loaded_q    <= 1'b0;
            load_done_q <= 1'b0;
            rd_pend_q   <= 1'b0;
            head_q      <= '0;
            head_vld_q  <= 1'b0;
            tail_q      <= '0;
            tail_vld_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            load_cnt_q  <= load_cnt_d;
            loaded_q    <= loaded_d;
            load_done_q <= load_done_d;
            rd_pend_q   <= rd_pend_d;
            head_q      <= head_d;
            head_vld_q  <= head_vld_d;
            tail_q      <= tail_d;
            tail_vld_q  <= tail_vld_d;
        end
    end

    assign load_done    = load_done_q;
    assign sample       = head_q;
    assign sample_valid = head_vld_q;

endmodule

// File: tb/tb_sine_table_sequencer.sv
module tb_sine_table_sequencer;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int PW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start_load = 1'b0;
    logic [DW-1:0] load_data = '0;
    logic          load_valid = 1'b0;
    logic          load_ready;
    logic          load_done;
    logic          run_en = 1'b0;
    logic [PW-1:0] tuning_word = '0;
    logic [DW-1:0] sample;
    logic          sample_valid;
    logic          sample_ready = 1'b0;
    logic [DW-1:0] mem_data;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_q = '0;

    sine_table_sequencer #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .PHASE_WIDTH(PW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start_load  (start_load),
        .load_data   (load_data),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .load_done   (load_done),
        .run_en      (run_en),
        .tuning_word (tuning_word),
        .sample      (sample),
        .sample_valid(sample_valid),
        .sample_ready(sample_ready),
        .mem_data    (mem_data),
        .mem_addr    (mem_addr),
        .mem_we      (mem_we),
        .mem_q       (mem_q)
    );

    always #5 clk = ~clk;

    // Single-port synchronous RAM, read-first.
    logic [DW-1:0] ram [16];
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_data;
        mem_q <= ram[mem_addr];
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // Table contents as the bench loaded them.
    logic [DW-1:0] tbl [16];

    // Scoreboard: expected samples queued at stream start, consumed on handshake.
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] mon_exp;
    logic [DW-1:0] prev_sample = '0;
    bit            prev_stall = 1'b0;
    bit            mon_en = 1'b0;
    int            recv = 0;

    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (prev_stall) begin
                check("hold_vld", sample_valid, 1);
                check("hold_dat", sample, prev_sample);
            end
            if (sample_valid && sample_ready) begin
                if (exp_q.size() == 0) begin
                    check("underflow", 1, 0);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("sample", sample, mon_exp);
                end
                recv++;
            end
            prev_stall  = sample_valid && !sample_ready;
            prev_sample = sample;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        start_load = 1'b0; load_valid = 1'b0; run_en = 1'b0; sample_ready = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_rdy"},  load_ready, 0);
        check({tag, "_done"}, load_done, 0);
        check({tag, "_smp"},  sample, 0);
        check({tag, "_vld"},  sample_valid, 0);
        check({tag, "_we"},   mem_we, 0);
        check({tag, "_addr"}, mem_addr, 0);
        check({tag, "_dat"},  mem_data, 0);
    endtask

    // Load 0x10..0x1F with a one-cycle gap before entry 5. When abort_at >= 0,
    // rst is raised mid-cycle while that entry is on the bus and left high.
    task automatic do_load(input int abort_at);
        start_load = 1'b1;
        tick();
        start_load = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (i == 5) begin
                load_valid = 1'b0;
                @(negedge clk);
                check("gap_we", mem_we, 0);
                check("gap_rdy", load_ready, 1);
                tick();
            end
            load_valid = 1'b1;
            load_data  = 8'h10 + 8'(i);
            tbl[i]     = 8'h10 + 8'(i);
            @(negedge clk);
            check("ld_addr", mem_addr, i);
            if (i == abort_at) begin
                rst = 1'b1;
                #1;
                check_idle_outputs("abort");
                load_valid = 1'b0;
                return;
            end
            check("ld_we", mem_we, 1);
            check("ld_dat", mem_data, 8'h10 + 8'(i));
            check("ld_rdy", load_ready, 1);
            check("ld_done_early", load_done, 0);
            tick();
        end
        load_valid = 1'b0;
        @(negedge clk);
        check("ld_done", load_done, 1);
        check("ld_rdy_after", load_ready, 0);
        check("ld_we_after", mem_we, 0);
        tick();
        @(negedge clk);
        check("ld_done_pulse", load_done, 0);
        tick();
    endtask

    // One RUN episode from phase 0: queue expected samples, stream, drain.
    task automatic run_seg(input logic [PW-1:0] tw, input int ncyc, input bit lat_chk,
                           input int stall_at, input bit rnd);
        logic [PW-1:0] ph;
        logic [AW-1:0] stall_addr;
        int lows;
        stall_addr = '0;
        exp_q.delete();
        ph = '0;
        for (int k = 0; k < 48; k++) begin
            exp_q.push_back(tbl[ph[PW-1 -: AW]]);
            ph = ph + tw;
        end
        recv = 0;
        tuning_word  = tw;
        sample_ready = 1'b1;
        run_en       = 1'b1;
        mon_en       = 1'b1;
        if (lat_chk) begin
            // run_en sampled at the next edge; address presented after it,
            // data returns one edge later and is buffered the edge after that.
            tick();
            @(negedge clk);
            check("lat_e1", sample_valid, 0);
            tick();
            @(negedge clk);
            check("lat_e2", sample_valid, 0);
            tick();
            @(negedge clk);
            check("lat_e3", sample_valid, 1);
            tick();
        end
        for (int c = 0; c < ncyc; c++) begin
            if (rnd) sample_ready = 1'($urandom_range(0, 1));
            else sample_ready = !(stall_at >= 0 && c >= stall_at && c < stall_at + 5);
            @(negedge clk);
            if (stall_at >= 0 && c == stall_at) stall_addr = mem_addr;
            if (stall_at >= 0 && c > stall_at && c < stall_at + 5)
                check("stall_addr", mem_addr, stall_addr);
            if (lat_chk) check("nogap", sample_valid, 1);
            tick();
        end
        run_en       = 1'b0;
        sample_ready = 1'b1;
        lows = 0;
        for (int t = 0; t < 40 && lows < 3; t++) begin
            @(negedge clk);
            lows = sample_valid ? 0 : lows + 1;
            tick();
        end
        check("drain", lows >= 3, 1);
        mon_en = 1'b0;
        check("recv_min", recv >= 8, 1);
        @(negedge clk);
        check("idle_addr", mem_addr, 0);
        tick();
    endtask

    initial begin
        #1;
        check_idle_outputs("rst");
        do_reset();

        // Load, then stream with several tuning words and backpressure.
        do_load(-1);
        run_seg(8'h10, 20, 1'b1, -1, 1'b0);
        run_seg(8'h08, 20, 1'b0, -1, 1'b0);
        run_seg(8'h30, 30, 1'b0, -1, 1'b1);
        run_seg(8'h10, 20, 1'b0, 6, 1'b0);

        // Reset clears the loaded flag: run_en alone must not start RUN.
        do_reset();
        run_en = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("noload_vld", sample_valid, 0);
            check("noload_we", mem_we, 0);
            check("noload_addr", mem_addr, 0);
            tick();
        end
        run_en = 1'b0;

        // Reload completely, then reset in the middle of a second load.
        do_load(-1);
        do_load(7);
        tick();
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("abort_nodone", load_done, 0);
            tick();
        end
        run_en = 1'b1;
        sample_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            check("abort_norun_vld", sample_valid, 0);
            check("abort_norun_addr", mem_addr, 0);
            tick();
        end
        run_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1);
    end

endmodule
